encode83_deb: RTL
=================

ENCODE83_DEB -- requirements
Module: encode83_deb

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 4, giving the consecutive-cycle stability count required to accept an input pattern (legal range 1..255).
REQ-002 SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST_N  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port SW  input  8  raw switch/button lines, asynchronous to CLK; bit i is request line i.
REQ-005 SHALL have port CODE  output  3  binary index of the highest-numbered active line in the accepted pattern.
REQ-006 SHALL have port VALID  output  1  high when the accepted pattern has at least one bit set.
REQ-007 SHALL have port MULTI  output  1  high when the accepted pattern has two or more bits set.
REQ-008 SHALL have port NEW  output  1  one-cycle pulse when an accepted pattern differs from the previously accepted pattern.
REQ-009 SHALL have port EVT_CNT  output  8  running count of NEW pulses.

Function
REQ-010 SHALL pass SW through a 2-stage flip-flop synchronizer (sync1, sync2) before any other use.
REQ-011 SHALL hold an 8-bit candidate register CAND and an 8-bit stability counter CNT.
REQ-012 Each cycle with sync2 != CAND: SHALL load CAND <= sync2 and CNT <= 0.
REQ-013 Each cycle with sync2 == CAND and CNT < DEB_CYCLES: SHALL increment CNT.
REQ-014 Each cycle with sync2 == CAND and CNT == DEB_CYCLES: SHALL hold CNT (saturate); no further acceptance.
REQ-015 Acceptance SHALL occur in a cycle where sync2 == CAND and CNT == DEB_CYCLES-1: stable pattern STB <= CAND.
REQ-016 CODE, VALID and MULTI SHALL be registered, computed from CAND, and updated on the same edge as STB.
REQ-017 Priority rule: CODE = index of the most significant set bit of the accepted pattern. If the pattern is all-zero, CODE = 0 and VALID = 0.
REQ-018 NEW SHALL be high for exactly the one cycle following an acceptance edge where CAND != the old STB. Otherwise NEW SHALL be low, including re-acceptance of an identical pattern.
REQ-019 EVT_CNT SHALL increment by 1 on every edge that sets NEW, and SHALL wrap from 255 to 0.
REQ-020 Latency: an SW change sampled at edge N and then held SHALL appear on CODE/VALID/MULTI/NEW after edge N+DEB_CYCLES+2.
REQ-021 An SW pulse whose synchronized value persists fewer than DEB_CYCLES+1 cycles SHALL cause no output change and no NEW.
REQ-022 SW changing again before acceptance SHALL restart the count per REQ-012. Only the final stable pattern is accepted.
REQ-023 If SW returns to the accepted pattern before a new pattern is accepted, the outputs SHALL remain unchanged with no NEW.

Reset
REQ-024 With RST_N low at a rising CLK edge, SHALL clear sync1, sync2, CAND, CNT, STB, CODE, VALID, MULTI, NEW and EVT_CNT to 0.
REQ-025 Reset asserted mid-count or mid-NEW-pulse SHALL abort the operation: NEW = 0 in the following cycle and no pending acceptance survives.
REQ-026 After reset release with SW = 0, acceptance of 0 SHALL produce no NEW, because the pattern equals the reset STB.
REQ-027 RST_N deassertion SHALL take effect only at a CLK edge; no asynchronous path SHALL exist.

Verification (DEB_CYCLES = 4)
REQ-028 Reset with SW=8'h00, release, run 20 cycles -> CODE=0, VALID=0, MULTI=0, NEW never high, EVT_CNT=0.
REQ-029 Step SW to each of 8'h01, 8'h02, ... 8'h80 in turn, holding each 20 cycles -> CODE=0..7 respectively, VALID=1, MULTI=0. NEW pulses once per step exactly 6 edges after sampling. EVT_CNT=8.
REQ-030 SW=8'hA4 held -> CODE=7, VALID=1, MULTI=1. Then SW=8'h24 -> CODE=5, MULTI=1. Then SW=8'h04 -> CODE=2, MULTI=0.
REQ-031 From accepted 8'h01, pulse SW=8'h10 for 3 cycles then return to 8'h01 -> outputs unchanged, no NEW. The same pulse held 5 cycles -> CODE=4 with one NEW.
REQ-032 Generate 256 alternating 8'h01/8'h02 accepted changes -> EVT_CNT wraps to 0, with exactly one NEW per change.
REQ-033 Drive RST_N low for one edge, 3 cycles after an SW change -> all outputs 0 next cycle, and no late NEW or CODE update from the aborted count.

Source files
------------

// File: rtl/encode83_deb.sv
// Debounced 8-to-3 priority encoder for asynchronous switch lines.
// Synchronizes, debounces, then encodes the highest active request line.
module encode83_deb #(
  parameter int DEB_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] SW,
  output logic [2:0] CODE,
  output logic       VALID,
  output logic       MULTI,
  output logic       NEW,
  output logic [7:0] EVT_CNT
);

  localparam logic [7:0] DEB_Q  = 8'(DEB_CYCLES);
  localparam logic [7:0] DEB_M1 = 8'(DEB_CYCLES - 1);

  logic [7:0] sync1_q, sync2_q;
  logic [7:0] cand_q, cand_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] stb_q, stb_d;
  logic [2:0] code_q, code_d;
  logic       valid_q, valid_d;
  logic       multi_q, multi_d;
  logic       new_q, new_d;
  logic [7:0] evt_q, evt_d;

  function automatic logic [2:0] prio(input logic [7:0] v);
    prio = 3'd0;
    for (int i = 0; i < 8; i++)
      if (v[i]) prio = 3'(i);
  endfunction

  always_comb begin
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    stb_d   = stb_q;
    code_d  = code_q;
    valid_d = valid_q;
    multi_d = multi_q;
    new_d   = 1'b0;
    evt_d   = evt_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = 8'd0;
    end else begin
      if (cnt_q < DEB_Q)
        cnt_d = cnt_q + 8'd1;
      // acceptance fires once; saturated CNT blocks re-acceptance
      if (cnt_q == DEB_M1) begin
        stb_d   = cand_q;
        code_d  = prio(cand_q);
        valid_d = |cand_q;
        multi_d = |(cand_q & (cand_q - 8'd1));
        if (cand_q != stb_q) begin
          new_d = 1'b1;
          evt_d = evt_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      stb_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
      new_q   <= 1'b0;
      evt_q   <= '0;
    end else begin
      sync1_q <= SW;
      sync2_q <= sync1_q;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      stb_q   <= stb_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      multi_q <= multi_d;
      new_q   <= new_d;
      evt_q   <= evt_d;
    end
  end

  assign CODE    = code_q;
  assign VALID   = valid_q;
  assign MULTI   = multi_q;
  assign NEW     = new_q;
  assign EVT_CNT = evt_q;

endmodule
